// File: rtl/vend_credit_ctrl.sv
// Vending transaction controller: coin credit accumulation, product selection and price check,
// dispenser handshake with timeout refund, and change payout one unit per cycle.
module vend_credit_ctrl #(
    parameter int CREDIT_W     = 8,
    parameter int PRICE0       = 25,
    parameter int PRICE1       = 50,
    parameter int PRICE2       = 75,
    parameter int PRICE3       = 100,
    parameter int MAX_CREDIT   = 200,
    parameter int DISP_TIMEOUT = 15,
    parameter int CHANGE_UNIT  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_val,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    input  logic                disp_ack,
    output logic                disp_req,
    output logic [1:0]          disp_id,
    output logic                chg_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          state,
    output logic                coin_reject,
    output logic                short_pay,
    output logic                err_timeout
);

    // state    | meaning
    // IDLE     | no credit, waiting for first coin
    // CREDIT   | credit held, accepting coins / selection / cancel
    // CHECK    | one cycle: compare credit against price of latched product
    // DISPENSE | disp_req held, waiting for ack or timeout
    // CHANGE   | paying out credit one CHANGE_UNIT per cycle
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CREDIT   = 3'd1,
        S_CHECK    = 3'd2,
        S_DISPENSE = 3'd3,
        S_CHANGE   = 3'd4
    } state_t;

    localparam int TMR_W = $clog2(DISP_TIMEOUT) + 1;

    localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);
    localparam logic [CREDIT_W-1:0] P0_C    = CREDIT_W'(PRICE0);
    localparam logic [CREDIT_W-1:0] P1_C    = CREDIT_W'(PRICE1);
    localparam logic [CREDIT_W-1:0] P2_C    = CREDIT_W'(PRICE2);
    localparam logic [CREDIT_W-1:0] P3_C    = CREDIT_W'(PRICE3);
    localparam logic [TMR_W-1:0]    TMR_LD  = TMR_W'(DISP_TIMEOUT - 1);

    state_t              state_q, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic [1:0]          disp_id_q, disp_id_nxt;
    logic [TMR_W-1:0]    tmr_q, tmr_nxt;
    logic                disp_req_q, disp_req_nxt;
    logic                chg_q, chg_nxt;
    logic                rej_q, rej_nxt;
    logic                short_q, short_nxt;
    logic                tout_q, tout_nxt;

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] price;

    // Sum kept one bit wider so a coin that wraps the credit register is still rejected.
    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_ok  = coin_valid && (coin_sum <= MAX_C);

    always_comb begin
        price = P0_C;
        case (disp_id_q)
            2'd0: price = P0_C;
            2'd1: price = P1_C;
            2'd2: price = P2_C;
            2'd3: price = P3_C;
            default: price = P0_C;
        endcase
    end

    always_comb begin
        state_nxt    = state_q;
        credit_nxt   = credit_q;
        disp_id_nxt  = disp_id_q;
        tmr_nxt      = tmr_q;
        disp_req_nxt = 1'b0;
        chg_nxt      = 1'b0;
        rej_nxt      = 1'b0;
        short_nxt    = 1'b0;
        tout_nxt     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (coin_ok) begin
                    credit_nxt = coin_sum[CREDIT_W-1:0];
                    state_nxt  = S_CREDIT;
                end else begin
                    rej_nxt = coin_valid;
                end
            end

            S_CREDIT: begin
                if (cancel) begin
                    rej_nxt   = coin_valid;
                    state_nxt = S_CHANGE;
                end else begin
                    if (coin_ok) begin
                        credit_nxt = coin_sum[CREDIT_W-1:0];
                    end else begin
                        rej_nxt = coin_valid;
                    end
                    if (sel_valid) begin
                        disp_id_nxt = sel_id;
                        state_nxt   = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                rej_nxt = coin_valid;
                if (credit_q >= price) begin
                    credit_nxt   = credit_q - price;
                    disp_req_nxt = 1'b1;
                    tmr_nxt      = TMR_LD;
                    state_nxt    = S_DISPENSE;
                end else begin
                    short_nxt = 1'b1;
                    state_nxt = S_CREDIT;
                end
            end

            S_DISPENSE: begin
                rej_nxt = coin_valid;
                if (disp_ack) begin
                    tmr_nxt   = '0;
                    state_nxt = (credit_q != '0) ? S_CHANGE : S_IDLE;
                end else if (tmr_q == '0) begin
                    // Refund restores the pre-purchase credit, which never exceeded MAX_CREDIT.
                    tout_nxt   = 1'b1;
                    credit_nxt = credit_q + price;
                    state_nxt  = S_CHANGE;
                end else begin
                    tmr_nxt      = tmr_q - 1'b1;
                    disp_req_nxt = 1'b1;
                end
            end

            S_CHANGE: begin
                rej_nxt = coin_valid;
                if (credit_q >= UNIT_C) begin
                    chg_nxt    = 1'b1;
                    credit_nxt = credit_q - UNIT_C;
                end else begin
                    state_nxt = (credit_q == '0) ? S_IDLE : S_CREDIT;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            disp_id_q  <= '0;
            tmr_q      <= '0;
            disp_req_q <= 1'b0;
            chg_q      <= 1'b0;
            rej_q      <= 1'b0;
            short_q    <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            credit_q   <= credit_nxt;
            disp_id_q  <= disp_id_nxt;
            tmr_q      <= tmr_nxt;
            disp_req_q <= disp_req_nxt;
            chg_q      <= chg_nxt;
            rej_q      <= rej_nxt;
            short_q    <= short_nxt;
            tout_q     <= tout_nxt;
        end
    end

    assign state       = state_q;
    assign credit      = credit_q;
    assign disp_id     = disp_id_q;
    assign disp_req    = disp_req_q;
    assign chg_pulse   = chg_q;
    assign coin_reject = rej_q;
    assign short_pay   = short_q;
    assign err_timeout = tout_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl: purchase, change, short pay, credit ceiling,
// dispenser timeout refund, cancel with residue and asynchronous reset mid-dispense.
module tb_vend_credit_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_val = '0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = '0;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       disp_req;
    logic [1:0] disp_id;
    logic       chg_pulse;
    logic [7:0] credit;
    logic [2:0] state;
    logic       coin_reject;
    logic       short_pay;
    logic       err_timeout;

    int n_vec = 0;
    int n_bad = 0;

    vend_credit_ctrl dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_id(sel_id),
        .cancel(cancel), .disp_ack(disp_ack),
        .disp_req(disp_req), .disp_id(disp_id), .chg_pulse(chg_pulse),
        .credit(credit), .state(state), .coin_reject(coin_reject),
        .short_pay(short_pay), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int v);
        coin_valid = 1'b1;
        coin_val   = 8'(v);
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic sel(input int id);
        sel_valid = 1'b1;
        sel_id    = 2'(id);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic ack();
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
    endtask

    // Runs while in CHANGE; counts chg_pulse cycles, cycles spent, stray err_timeout cycles.
    task automatic run_change(output int pulses, output int cycles, output int touts);
        pulses = 0;
        cycles = 0;
        touts  = 0;
        while (state == 3'd4 && cycles < 60) begin
            tick();
            cycles++;
            if (chg_pulse) pulses++;
            if (err_timeout) touts++;
        end
        if (cycles >= 60) chg("change_bound_expired", cycles, 0);
    endtask

    task automatic chg(input string tag, input int got, input int exp);
        chk(tag, got, exp);
    endtask

    int p, c, t, hi;

    initial begin
        // reset
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_credit", credit, 0);
        chk("rst_disp_req", disp_req, 0);
        chk("rst_disp_id", disp_id, 0);
        chk("rst_pulses", {chg_pulse, coin_reject, short_pay, err_timeout}, 0);
        rst = 1'b0;
        tick();

        // 1: 25+25, select 1, ack after 3 cycles
        coin(25);
        chk("t1_state_credit", state, 1);
        coin(25);
        chk("t1_credit50", credit, 50);
        sel(1);
        chk("t1_check", state, 2);
        chk("t1_disp_id", disp_id, 1);
        tick();
        chk("t1_dispense", state, 3);
        chk("t1_req", disp_req, 1);
        chk("t1_credit0", credit, 0);
        coin(5);
        chk("t1_coin_rej_disp", coin_reject, 1);
        chk("t1_credit_keep", credit, 0);
        tick();
        chk("t1_req_held", disp_req, 1);
        chk("t1_rej_1cyc", coin_reject, 0);
        ack();
        chk("t1_idle", state, 0);
        chk("t1_req_low", disp_req, 0);
        chk("t1_no_chg", chg_pulse, 0);

        // 2: credit 100, product 0, 15 change pulses
        coin(100);
        sel(0);
        tick();
        chk("t2_credit75", credit, 75);
        ack();
        chk("t2_change", state, 4);
        run_change(p, c, t);
        chk("t2_pulses", p, 15);
        chk("t2_cycles", c, 16);
        chk("t2_end_state", state, 0);
        chk("t2_end_credit", credit, 0);

        // 3: short pay then top-up
        coin(30);
        sel(2);
        tick();
        chk("t3_short", short_pay, 1);
        chk("t3_back_credit", state, 1);
        chk("t3_credit30", credit, 30);
        tick();
        chk("t3_short_1cyc", short_pay, 0);
        coin(50);
        chk("t3_credit80", credit, 80);
        sel(2);
        tick();
        chk("t3_credit5", credit, 5);
        ack();
        run_change(p, c, t);
        chk("t3_pulses", p, 1);
        chk("t3_end_state", state, 0);

        // 4: credit ceiling
        coin(100);
        coin(90);
        coin(20);
        chk("t4_reject", coin_reject, 1);
        chk("t4_credit190", credit, 190);
        coin(10);
        chk("t4_rej_clear", coin_reject, 0);
        chk("t4_credit200", credit, 200);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        run_change(p, c, t);
        chk("t4_pulses", p, 40);
        chk("t4_end_state", state, 0);

        // 5: dispenser timeout with refund
        coin(50);
        sel(1);
        tick();
        hi = 0;
        while (disp_req && hi < 30) begin
            hi++;
            tick();
        end
        chk("t5_req_cycles", hi, 15);
        chk("t5_err_timeout", err_timeout, 1);
        chk("t5_refund", credit, 50);
        chk("t5_change", state, 4);
        run_change(p, c, t);
        chk("t5_pulses", p, 10);
        chk("t5_tout_1cyc", t, 0);
        chk("t5_end_state", state, 0);

        // 6: cancel with residue, then async reset mid-dispense
        coin(42);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        run_change(p, c, t);
        chk("t6_pulses", p, 8);
        chk("t6_residue", credit, 2);
        chk("t6_state_credit", state, 1);
        coin(23);
        sel(0);
        tick();
        chk("t6_dispense", disp_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_state", state, 0);
        chk("t6_rst_credit", credit, 0);
        chk("t6_rst_req", disp_req, 0);
        chk("t6_rst_pulses", {chg_pulse, coin_reject, short_pay, err_timeout}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t6_post_state", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
